// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the multi-pass shift sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package shift_seq_pkg;

  localparam int DATA_W    = 8;
  localparam int CHUNK_MAX = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest amount the two-bit shifter can apply in one pass.
  function automatic logic [1:0] next_chunk(input logic [2:0] remaining);
    if (remaining > 3'(CHUNK_MAX)) begin
      return 2'(CHUNK_MAX);
    end
    return remaining[1:0];
  endfunction

endpackage

// File: rtl/ari_shift.sv
// Combinational 8-bit shifter, 0..3 positions: left logical, right arithmetic, or rotate.
// Latency: combinational; the driver allows a settle time before sampling c.
// Backpressure: none, pure function of its inputs.
module ari_shift
  import shift_seq_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic              left,
  input  logic              rotate,
  input  logic [1:0]        amt,
  output logic [DATA_W-1:0] c
);

  logic [2*DATA_W-1:0] dbl_l;
  logic [2*DATA_W-1:0] dbl_r;

  // Rotates come from a doubled operand; plain shifts zero-fill left, sign-fill right.
  always_comb begin
    dbl_l = {a, a} << amt;
    dbl_r = {a, a} >> amt;
    if (left) begin
      c = rotate ? dbl_l[2*DATA_W-1:DATA_W] : (a << amt);
    end else begin
      c = rotate ? dbl_r[DATA_W-1:0] : DATA_W'($signed(a) >>> amt);
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Runs the two-bit shifter in passes of up to 3 to shift/rotate an 8-bit operand by 0..7.
// Latency: passes*SETTLE_CYCLES edges after acceptance for n>0; response the cycle after acceptance for n=0.
// Backpressure: one request in flight; req_ready only in IDLE, response held in DONE until rsp_ready.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int AMT_W         = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_left,
  input  logic              req_rotate,
  input  logic [AMT_W-1:0]  req_amt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [DATA_W-1:0] sh_a,
  output logic              sh_left,
  output logic              sh_rotate,
  output logic [1:0]        sh_amt,
  input  logic [DATA_W-1:0] sh_c
);

  // Counter reload: a pass spans SETTLE_CYCLES edges, capturing on the one where the count is 0.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] work;
  logic [AMT_W-1:0]  remaining;
  logic [AMT_W-1:0]  new_rem;
  logic [3:0]        settle_cnt;
  logic              accept;
  logic              pass_done;

  assign accept    = (state == IDLE) && req_valid;
  assign pass_done = (state == PASS) && (settle_cnt == 4'd0);
  assign new_rem   = remaining - AMT_W'(sh_amt);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a zero amount skips straight to DONE; the last capture leaves PASS.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = (req_amt == '0) ? DONE : PASS;
        end
      end
      PASS: begin
        if (pass_done && (new_rem == '0)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    req_ready = 1'b1;
      PASS:    busy      = 1'b1;
      DONE: begin
        rsp_valid = 1'b1;
        busy      = 1'b1;
      end
      default: req_ready = 1'b0;
    endcase
  end

  // Working register, remaining count, shifter controls and settle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work       <= '0;
      remaining  <= '0;
      settle_cnt <= '0;
      sh_left    <= 1'b0;
      sh_rotate  <= 1'b0;
      sh_amt     <= 2'd0;
    end else begin
      if (accept) begin
        work      <= req_data;
        sh_left   <= req_left;
        sh_rotate <= req_rotate;
        remaining <= req_amt;
        if (req_amt != '0) begin
          sh_amt     <= next_chunk(req_amt);
          settle_cnt <= SETTLE_LOAD;
        end
      end else if (state == PASS) begin
        if (settle_cnt == 4'd0) begin
          work      <= sh_c;
          remaining <= new_rem;
          if (new_rem == '0) begin
            sh_amt <= 2'd0;
          end else begin
            sh_amt     <= next_chunk(new_rem);
            settle_cnt <= SETTLE_LOAD;
          end
        end else begin
          settle_cnt <= settle_cnt - 4'd1;
        end
      end
    end
  end

  // The shifter always sees the working register; in IDLE/DONE sh_amt=0 makes it a pass-through.
  assign sh_a     = work;
  assign rsp_data = work;

  // Shifter inputs must not move while the combinational path is settling.
  a_pass_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state == PASS && settle_cnt != 4'd0) |=> $stable({sh_a, sh_amt, sh_left, sh_rotate}));

  // A stalled response stays valid with unchanged data.
  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_data)));

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic       req_left;
  logic       req_rotate;
  logic [2:0] req_amt;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       busy;
  logic [7:0] sh_a;
  logic       sh_left;
  logic       sh_rotate;
  logic [1:0] sh_amt;
  logic [7:0] sh_c;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.SETTLE_CYCLES(S), .AMT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_left(req_left), .req_rotate(req_rotate), .req_amt(req_amt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .sh_a(sh_a), .sh_left(sh_left), .sh_rotate(sh_rotate),
    .sh_amt(sh_amt), .sh_c(sh_c)
  );

  ari_shift u_shift (
    .a(sh_a), .left(sh_left), .rotate(sh_rotate), .amt(sh_amt), .c(sh_c)
  );

  typedef struct {
    logic [7:0] data;
    logic       left;
    logic       rotate;
    logic [2:0] amt;
    int         passes;
    logic [1:0] c0;
    logic [1:0] c1;
    logic [1:0] c2;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  function automatic void check(input string tag, input string what, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", tag, what, act, exp);
    end
  endfunction

  function automatic logic [1:0] chunk_of(input vec_t v, input int k);
    case (k)
      0:       return v.c0;
      1:       return v.c1;
      2:       return v.c2;
      default: return 2'd0;
    endcase
  endfunction

  // Called at a negedge; returns at a negedge with rsp_valid high or the budget spent.
  task automatic wait_rsp(input string tag);
    int guard = 0;
    while (!rsp_valid && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check(tag, "rsp_valid_timeout", int'(rsp_valid), 1);
  endtask

  // Full transaction: present, accept, follow each pass, check result, handshake.
  task automatic run_op(input vec_t v, input string tag);
    int lat = 0;
    int guard = 0;
    while (!req_ready && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check(tag, "req_ready", int'(req_ready), 1);
    req_data   = v.data;
    req_left   = v.left;
    req_rotate = v.rotate;
    req_amt    = v.amt;
    req_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    while (!rsp_valid && lat < 40) begin
      check(tag, "sh_amt", int'(sh_amt), int'(chunk_of(v, lat / S)));
      @(negedge clk);
      lat++;
    end
    check(tag, "latency", lat, v.passes * S);
    check(tag, "rsp_valid", int'(rsp_valid), 1);
    check(tag, "rsp_data", int'(rsp_data), int'(v.exp));
    check(tag, "done_sh_amt", int'(sh_amt), 0);
    check(tag, "done_req_ready", int'(req_ready), 0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check(tag, "post_rsp_valid", int'(rsp_valid), 0);
    check(tag, "post_req_ready", int'(req_ready), 1);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    vec_t v;
    // data, left, rotate, amt, passes, chunks, expected result
    vecs[0] = '{8'h96, 1'b0, 1'b0, 3'd7, 3, 2'd3, 2'd3, 2'd1, 8'hFF};
    vecs[1] = '{8'h96, 1'b1, 1'b0, 3'd5, 2, 2'd3, 2'd2, 2'd0, 8'hC0};
    vecs[2] = '{8'h96, 1'b0, 1'b1, 3'd4, 2, 2'd3, 2'd1, 2'd0, 8'h69};
    vecs[3] = '{8'h81, 1'b1, 1'b1, 3'd7, 3, 2'd3, 2'd3, 2'd1, 8'hC0};
    vecs[4] = '{8'h5A, 1'b1, 1'b0, 3'd0, 0, 2'd0, 2'd0, 2'd0, 8'h5A};
    vecs[5] = '{8'h96, 1'b0, 1'b0, 3'd3, 1, 2'd3, 2'd0, 2'd0, 8'hF2};
    vecs[6] = '{8'h6C, 1'b0, 1'b0, 3'd2, 1, 2'd2, 2'd0, 2'd0, 8'h1B};
    vecs[7] = '{8'h01, 1'b1, 1'b0, 3'd1, 1, 2'd1, 2'd0, 2'd0, 8'h02};
    vecs[8] = '{8'h01, 1'b1, 1'b0, 3'd7, 3, 2'd3, 2'd3, 2'd1, 8'h80};
    vecs[9] = '{8'h3C, 1'b0, 1'b1, 3'd6, 2, 2'd3, 2'd3, 2'd0, 8'hF0};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_data   = 8'h00;
    req_left   = 1'b0;
    req_rotate = 1'b0;
    req_amt    = 3'd0;
    rsp_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", "rsp_valid", int'(rsp_valid), 0);
    check("reset", "busy", int'(busy), 0);
    check("reset", "sh_a", int'(sh_a), 0);
    check("reset", "sh_ctl", int'({sh_left, sh_rotate, sh_amt}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset", "req_ready", int'(req_ready), 1);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: response held for 5 cycles while a second request waits.
    req_data = 8'h96; req_left = 1'b1; req_rotate = 1'b0; req_amt = 3'd1;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp("bp");
    req_data = 8'h01; req_left = 1'b1; req_rotate = 1'b0; req_amt = 3'd1;
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp", "hold_rsp_valid", int'(rsp_valid), 1);
      check("bp", "hold_rsp_data", int'(rsp_data), 8'h2C);
      check("bp", "hold_req_ready", int'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp", "handshake_rsp_valid", int'(rsp_valid), 0);
    check("bp", "no_accept_in_done", int'(busy), 0);
    @(negedge clk);
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    check("bp", "accept_after_bubble", int'(busy), 1);
    check("bp", "second_sh_amt", int'(sh_amt), 1);
    check("bp", "second_sh_a", int'(sh_a), 8'h01);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp("bp2");
    check("bp2", "rsp_data", int'(rsp_data), 8'h02);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset during the second pass of an amt=7 operation.
    v = vecs[0];
    req_data = v.data; req_left = v.left; req_rotate = v.rotate; req_amt = v.amt;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (S) @(negedge clk);
    check("rstmid", "in_second_pass", int'(sh_amt), 3);
    check("rstmid", "busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rstmid", "busy", int'(busy), 0);
    check("rstmid", "rsp_valid", int'(rsp_valid), 0);
    check("rstmid", "sh_a", int'(sh_a), 0);
    check("rstmid", "sh_ctl", int'({sh_left, sh_rotate, sh_amt}), 0);
    check("rstmid", "req_ready", int'(req_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rstmid", "idle_after", int'({rsp_valid, busy}), 0);
    end
    v = '{8'h01, 1'b1, 1'b0, 3'd1, 1, 2'd1, 2'd0, 2'd0, 8'h02};
    run_op(v, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Multi-cycle controller that runs the 8-bit two-bit-amount shifter datapath (ari_shift: left/rotate/amt[1:0]) to perform shifts and rotates of 0..7 positions. It accepts one request over a valid/ready handshake and splits the amount into passes of at most 3. It drives the shifter, waits a programmable settle time per pass for the NAND-delay combinational path, and captures each result into a working register. It sits between the ALU-op decoder and the shifter and owns the shifter exclusively.

Parameters:
SETTLE_CYCLES, 2, clock cycles each pass holds shifter inputs before capturing sh_c; legal range 1..15.
AMT_W, 3, width of the requested shift amount; fixed at 3 (max 7).

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept (IDLE only)
req_data  in  8  operand
req_left  in  1  1 = left, 0 = right
req_rotate  in  1  1 = rotate, 0 = shift (left logical zero-fill, right arithmetic sign-fill)
req_amt  in  AMT_W  total positions 0..7
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  8  result (working register)
busy  out  1  high in PASS or DONE
sh_a  out  8  shifter operand (working register)
sh_left  out  1  shifter direction (latched req_left)
sh_rotate  out  1  shifter mode (latched req_rotate)
sh_amt  out  2  shifter pass amount
sh_c  in  8  shifter result

Behaviour:
- Reset (async, rst_n=0): state=IDLE; work, remaining, settle_cnt = 0. Outputs: req_ready=1 once released, rsp_valid=0, busy=0, sh_a=0, sh_left=0, sh_rotate=0, sh_amt=0. Reset mid-pass aborts the operation; no response is produced.
- States: IDLE, PASS, DONE.
- IDLE: req_ready=1. On req_valid at an edge, latch work<=req_data, left, rotate, remaining<=req_amt.
  - req_amt=0 -> DONE; rsp_valid rises the next cycle and rsp_data=req_data.
  - Otherwise -> PASS, with sh_amt<=min(req_amt,3) and settle_cnt<=SETTLE_CYCLES-1.
- PASS: sh_a, sh_left, sh_rotate and sh_amt are registered and held stable for the whole pass. settle_cnt decrements every cycle. At the edge where settle_cnt==0:
  - work<=sh_c and remaining<=remaining-sh_amt.
  - If the new remaining is 0 -> DONE and sh_amt<=0.
  - Else stay in PASS, with sh_amt<=min(new remaining,3) and settle_cnt reloaded.
- Pass chunking: amount n gives ceil(n/3) passes (7 -> 3,3,1; 4 -> 3,1; 3 -> 3). Direction and mode are the same for every pass. Arithmetic-right chunks compose correctly because the sign bit is preserved on each pass.
- DONE: rsp_valid=1 and rsp_data=work, both held stable until rsp_ready. On rsp_valid&rsp_ready -> IDLE, and rsp_valid drops the next cycle.
- req_ready=0 outside IDLE. A request presented then is not accepted and must be held by the requester. There is no back-to-back acceptance in DONE; a minimum one-cycle IDLE bubble exists between operations.
- Latency from the acceptance edge to rsp_valid high: ceil(n/3)*SETTLE_CYCLES cycles for n>0, and 1 cycle for n=0.
- sh_a always equals work. In IDLE/DONE, sh_amt=0, so the shifter passes work through unchanged.
- A simultaneous rsp_ready and req_valid in DONE completes the response only. The new request is accepted in the following IDLE cycle.

Decomposition:
- Package shift_seq_pkg:
  - state enum (IDLE, PASS, DONE)
  - DATA_W=8, CHUNK_MAX=3
  - function next_chunk(remaining) returning min(remaining,3) as 2 bits
- No sub-module inside. The bench top instantiates ari_shift and wires sh_a, sh_left, sh_rotate, sh_amt and sh_c to the sequencer.

Test Plan:
- SETTLE_CYCLES=2, data=0x96, right arithmetic, amt=7 -> sh_amt sequence 3,3,1; rsp_data=0xFF; rsp_valid 6 cycles after acceptance.
- data=0x96, left shift, amt=5 -> passes 3,2; rsp_data=0xC0; latency 4 cycles.
- data=0x96, rotate right, amt=4 -> rsp_data=0x69. data=0x81, rotate left, amt=7 -> rsp_data=0xC0.
- data=0x5A, amt=0 -> rsp_valid 1 cycle after acceptance; rsp_data=0x5A; sh_amt stays 0.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0, and a pending req_valid is not accepted until after the handshake plus the IDLE cycle.
- Assert rst_n=0 during the second pass of an amt=7 op -> immediate IDLE with all outputs at reset values and no rsp_valid. A subsequent request with data=0x01, left, amt=1 -> rsp_data=0x02.
